post_trace_buffer: RTL and testbench
====================================

Name: post_trace_buffer

Overview:
Parametrised post-synaptic buffer for the SNN core. Accepts a serial per-neuron spike stream, one neuron per valid cycle, indices 0..N_NRN-1 in order. Maintains:
- a spike shift register
- two exponentially decaying traces per neuron (y1, y2) plus a previous-y2 snapshot
- a clamped lateral-inhibition accumulator
- saturating per-neuron spike counters

Sits between the neuron array and the STDP/learning unit.

Parameters:
N_NRN, 18, neurons per frame
IDX_W, 5, neuron index width (2^IDX_W >= N_NRN)
TR_W, 16, trace width (unsigned)
Y1_SHIFT, 4, y1 decay shift
Y2_SHIFT, 5, y2 decay shift
INH_W, 25, inhibition width (signed)
INH_STEP, 458752, inhibition added per spike
INH_MAX, 655360, inhibition clamp value
CNT_W, 7, spike counter width

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
i_valid  in  1  stream qualifier
i_spike  in  1  spike of neuron i_idx
i_idx  in  IDX_W  neuron index
i_cnt_clr  in  1  synchronous clear of all counters
o_spike_buf  out  N_NRN  last N_NRN spikes; newest at MSB
o_y1_trace  out  N_NRN*TR_W  y1 traces; neuron n at [n*TR_W +: TR_W]
o_y2_trace_buf  out  N_NRN*TR_W  y2 value before its latest update
o_inhbt  out  INH_W signed  current inhibition accumulator
o_post_cnt  out  N_NRN*CNT_W  spike counters
o_valid  out  1  frame-complete pulse
o_err  out  1  out-of-range index pulse

Behaviour:
- Reset: every register and every output is 0. Reset mid-frame aborts the frame; the pipeline is flushed.
- Index check: a valid beat with i_idx >= N_NRN is dropped entirely (no state change). o_err pulses 1 cycle later.
- Spike buffer: on each accepted beat, shift right with i_spike inserted at bit N_NRN-1.
- Inhibition:
  - idx 0 loads (i_spike ? INH_STEP : 0).
  - Any other idx loads min(inh + (i_spike ? INH_STEP : 0), INH_MAX).
  - The sum is computed at INH_W+1 bits, so it never wraps. Output is registered, latency 1.
- Traces use a 2-stage pipeline.
  - S1 (cycle after the beat) registers the operands.
  - S2 (next cycle) writes the result. Write latency is 2 cycles after the beat.
  - Spike: y1 and y2 are set to all-ones.
  - No spike: y1 <= y1 - (y1 >> Y1_SHIFT) and y2 <= y2 - (y2 >> Y2_SHIFT). Unsigned, with no underflow possible.
  - On every write, y2_trace_buf[n] receives the old y2[n].
- Hazard: a same-index beat on back-to-back cycles (possible after a restart at idx 0 with N_NRN=1) takes S1 operands forwarded from the S2 result, never the stale register.
- Counters:
  - An accepted spike increments cnt[idx], saturating at 2^CNT_W-1.
  - i_cnt_clr has priority over a same-cycle increment; that spike is lost.
- o_valid: 1-cycle pulse, 1 cycle after an accepted beat with idx == N_NRN-1. Traces for that neuron land 1 cycle after o_valid.
- Gaps: i_valid may deassert at any point; all state holds.
- No ordering check beyond range: a repeated or skipped index is processed as given.

Optional Feature:
POST_BUF_WTA_EN
- Defined: adds ports o_winner_idx (IDX_W) and o_winner_vld (1).
  - Tracks the lowest index that spiked in the current frame; tracking restarts on an idx 0 beat.
  - Both are registered alongside o_valid.
  - o_winner_vld = 1 if any neuron spiked in the frame; o_winner_idx = 0 when there was no spike.
  - Both hold until the next o_valid. Reset value is 0.
- Undefined: the ports and logic are absent.

Decomposition:
- Shared package snn_post_pkg: default widths, INH_STEP and INH_MAX constants, trace_t typedef (TR_W), and a decay function (value, shift).
- One sub-module, post_trace_lane: one neuron's y1/y2/y2_buf registers with the S2 write enable. Instantiated N_NRN times by generate.

Test Plan:
- Reset, then frame with no spikes -> all traces 0, o_inhbt 0, o_valid pulses 1 cycle after the idx 17 beat.
- Spike on idx 3 only -> y1[3]=y2[3]=0xFFFF. Next no-spike frame -> y1[3]=0xF000, y2[3]=0xF800, y2_buf[3]=0xFFFF.
- Spikes on idx 0,1,2 -> o_inhbt 458752, then 655360 (clamped), then stays 655360. Next frame idx 0 with no spike -> 0.
- Neuron 5 spikes in 130 frames, CNT_W=7 -> cnt[5] saturates at 127. i_cnt_clr asserted with a spike beat -> 0.
- i_idx=20 with valid -> o_err pulses, no state change. i_valid gaps mid-frame -> identical results to a gapless frame.
- With POST_BUF_WTA_EN, spikes on idx 7 and 12 -> o_winner_idx=7, o_winner_vld=1 with o_valid.

Source files
------------

// File: rtl/post_trace_buffer_pkg.sv
// Shared definitions for the SNN post-synaptic buffer: default widths,
// inhibition constants, the trace type and the trace decay helper.
package snn_post_pkg;

    localparam int DEF_N_NRN    = 18;
    localparam int DEF_IDX_W    = 5;
    localparam int DEF_TR_W     = 16;
    localparam int DEF_Y1_SHIFT = 4;
    localparam int DEF_Y2_SHIFT = 5;
    localparam int DEF_INH_W    = 25;
    localparam int DEF_CNT_W    = 7;

    localparam int DEF_INH_STEP = 458752;
    localparam int DEF_INH_MAX  = 655360;

    typedef logic [DEF_TR_W-1:0] trace_t;

    // One exponential decay step; the subtrahend is never larger than the
    // value, so the unsigned result cannot underflow.
    function automatic trace_t decay(input trace_t value, input int shift);
        return value - (value >> shift);
    endfunction

endpackage

// File: rtl/post_trace_buffer_if.sv
// Serial spike stream into the post-synaptic buffer: one neuron per valid
// beat, plus the counter clear strobe. The neuron array drives it (master),
// the buffer consumes it (slave).
interface post_trace_buffer_if
    import snn_post_pkg::*;
#(
    parameter int IDX_W = DEF_IDX_W
) ();

    logic             i_valid;
    logic             i_spike;
    logic [IDX_W-1:0] i_idx;
    logic             i_cnt_clr;

    modport master (output i_valid, output i_spike, output i_idx, output i_cnt_clr);
    modport slave  (input  i_valid, input  i_spike, input  i_idx, input  i_cnt_clr);

endinterface

// File: rtl/post_trace_buffer_lane.sv
// One neuron's trace storage: y1, y2 and the snapshot of y2 taken just
// before its most recent update. Written only by the S2 stage.
module post_trace_lane #(
    parameter int TR_W = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            we,
    input  logic [TR_W-1:0] y1_nxt,
    input  logic [TR_W-1:0] y2_nxt,
    output logic [TR_W-1:0] y1,
    output logic [TR_W-1:0] y2,
    output logic [TR_W-1:0] y2_buf
);

    // Commit the S2 result and keep the y2 value it replaces
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            y1     <= '0;
            y2     <= '0;
            y2_buf <= '0;
        end else if (we) begin
            y1     <= y1_nxt;
            y2     <= y2_nxt;
            y2_buf <= y2;
        end
    end

endmodule

// File: rtl/post_trace_buffer.sv
// Post-synaptic buffer between the neuron array and the learning unit.
// Keeps the recent spike history, two decaying traces per neuron, a clamped
// lateral-inhibition accumulator and saturating spike counters.
// Optional winner-take-all tracking is built when POST_BUF_WTA_EN is defined.
module post_trace_buffer
    import snn_post_pkg::*;
#(
    parameter int N_NRN    = DEF_N_NRN,
    parameter int IDX_W    = DEF_IDX_W,
    parameter int TR_W     = DEF_TR_W,
    parameter int Y1_SHIFT = DEF_Y1_SHIFT,
    parameter int Y2_SHIFT = DEF_Y2_SHIFT,
    parameter int INH_W    = DEF_INH_W,
    parameter int INH_STEP = DEF_INH_STEP,
    parameter int INH_MAX  = DEF_INH_MAX,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     reset_n,
    post_trace_buffer_if.slave       in_if,
    output logic [N_NRN-1:0]         o_spike_buf,
    output logic [N_NRN*TR_W-1:0]    o_y1_trace,
    output logic [N_NRN*TR_W-1:0]    o_y2_trace_buf,
    output logic signed [INH_W-1:0]  o_inhbt,
    output logic [N_NRN*CNT_W-1:0]   o_post_cnt,
    output logic                     o_valid,
    output logic                     o_err
`ifdef POST_BUF_WTA_EN
    ,
    output logic [IDX_W-1:0]         o_winner_idx,
    output logic                     o_winner_vld
`endif
);

    localparam logic [IDX_W-1:0]        LAST_IDX   = IDX_W'(N_NRN - 1);
    localparam logic [CNT_W-1:0]        CNT_MAX    = '1;
    localparam logic signed [INH_W:0]   INH_STEP_W = (INH_W+1)'(INH_STEP);
    localparam logic signed [INH_W:0]   INH_MAX_W  = (INH_W+1)'(INH_MAX);

    // Clamp the widened inhibition sum to the ceiling
    function automatic logic signed [INH_W-1:0] inh_sat(input logic signed [INH_W:0] sum);
        if (sum > INH_MAX_W)
            return INH_MAX_W[INH_W-1:0];
        return sum[INH_W-1:0];
    endfunction

    // Counter increment that sticks at all-ones
    function automatic logic [CNT_W-1:0] cnt_sat(input logic [CNT_W-1:0] cnt);
        if (cnt == CNT_MAX)
            return cnt;
        return cnt + 1'b1;
    endfunction

    // ---- stage p0: incoming beat ----
    logic                    accept_p0;
    logic                    last_p0;
    logic signed [INH_W:0]   inh_sum_p0;
    trace_t                  y1_fw_p0;
    trace_t                  y2_fw_p0;

    // ---- stage p1: registered trace operands (S1) ----
    logic                    vld_p1;
    logic [IDX_W-1:0]        idx_p1;
    logic                    spike_p1;
    trace_t                  y1_op_p1;
    trace_t                  y2_op_p1;
    trace_t                  y1_nxt_p1;
    trace_t                  y2_nxt_p1;

    trace_t                  y1_q  [N_NRN];
    trace_t                  y2_q  [N_NRN];
    trace_t                  y2b_q [N_NRN];
    logic [CNT_W-1:0]        cnt_q [N_NRN];

    assign accept_p0  = in_if.i_valid && ({1'b0, in_if.i_idx} < (IDX_W+1)'(N_NRN));
    assign last_p0    = (in_if.i_idx == LAST_IDX);
    assign inh_sum_p0 = {o_inhbt[INH_W-1], o_inhbt} + (in_if.i_spike ? INH_STEP_W : '0);

    // Trace operand read, bypassing the register when S2 is writing the same neuron
    always_comb begin
        y1_fw_p0 = y1_q[in_if.i_idx];
        y2_fw_p0 = y2_q[in_if.i_idx];
        if (vld_p1 && (idx_p1 == in_if.i_idx)) begin
            y1_fw_p0 = y1_nxt_p1;
            y2_fw_p0 = y2_nxt_p1;
        end
    end

    // Beat-rate state: spike history, inhibition, frame/error pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_spike_buf <= '0;
            o_inhbt     <= '0;
            o_valid     <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            o_valid <= accept_p0 && last_p0;
            o_err   <= in_if.i_valid && !accept_p0;
            if (accept_p0) begin
                o_spike_buf <= {in_if.i_spike, o_spike_buf[N_NRN-1:1]};
                if (in_if.i_idx == '0)
                    o_inhbt <= in_if.i_spike ? INH_STEP_W[INH_W-1:0] : '0;
                else
                    o_inhbt <= inh_sat(inh_sum_p0);
            end
        end
    end

    // ---- stage p1 -> p2: S1 operand capture, S2 result written next edge ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1   <= 1'b0;
            idx_p1   <= '0;
            spike_p1 <= 1'b0;
            y1_op_p1 <= '0;
            y2_op_p1 <= '0;
        end else begin
            vld_p1 <= accept_p0;
            if (accept_p0) begin
                idx_p1   <= in_if.i_idx;
                spike_p1 <= in_if.i_spike;
                y1_op_p1 <= y1_fw_p0;
                y2_op_p1 <= y2_fw_p0;
            end
        end
    end

    // S2 result: a spike saturates both traces, otherwise they decay
    always_comb begin
        y1_nxt_p1 = spike_p1 ? '1 : decay(y1_op_p1, Y1_SHIFT);
        y2_nxt_p1 = spike_p1 ? '1 : decay(y2_op_p1, Y2_SHIFT);
    end

    genvar n;
    generate
        for (n = 0; n < N_NRN; n++) begin : g_lane
            post_trace_lane #(.TR_W(TR_W)) u_lane (
                .clk     (clk),
                .reset_n (reset_n),
                .we      (vld_p1 && (idx_p1 == IDX_W'(n))),
                .y1_nxt  (y1_nxt_p1),
                .y2_nxt  (y2_nxt_p1),
                .y1      (y1_q[n]),
                .y2      (y2_q[n]),
                .y2_buf  (y2b_q[n])
            );
            assign o_y1_trace[n*TR_W +: TR_W]     = y1_q[n];
            assign o_y2_trace_buf[n*TR_W +: TR_W] = y2b_q[n];
            assign o_post_cnt[n*CNT_W +: CNT_W]   = cnt_q[n];
        end
    endgenerate

    // Spike counters; a clear wins over a coincident increment
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_NRN; i++)
                cnt_q[i] <= '0;
        end else if (in_if.i_cnt_clr) begin
            for (int i = 0; i < N_NRN; i++)
                cnt_q[i] <= '0;
        end else if (accept_p0 && in_if.i_spike) begin
            for (int i = 0; i < N_NRN; i++)
                if (in_if.i_idx == IDX_W'(i))
                    cnt_q[i] <= cnt_sat(cnt_q[i]);
        end
    end

`ifdef POST_BUF_WTA_EN
    logic             trk_vld_q;
    logic [IDX_W-1:0] trk_idx_q;
    logic             trk_vld_d;
    logic [IDX_W-1:0] trk_idx_d;

    // Lowest spiking index so far in this frame; an idx 0 beat restarts it
    always_comb begin
        trk_vld_d = trk_vld_q;
        trk_idx_d = trk_idx_q;
        if (in_if.i_idx == '0) begin
            trk_vld_d = in_if.i_spike;
            trk_idx_d = '0;
        end else if (in_if.i_spike && (!trk_vld_q || (in_if.i_idx < trk_idx_q))) begin
            trk_vld_d = 1'b1;
            trk_idx_d = in_if.i_idx;
        end
    end

    // Track per beat and publish the winner together with the frame pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trk_vld_q    <= 1'b0;
            trk_idx_q    <= '0;
            o_winner_vld <= 1'b0;
            o_winner_idx <= '0;
        end else if (accept_p0) begin
            trk_vld_q <= trk_vld_d;
            trk_idx_q <= trk_idx_d;
            if (last_p0) begin
                o_winner_vld <= trk_vld_d;
                o_winner_idx <= trk_vld_d ? trk_idx_d : '0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_post_trace_buffer.sv
// Scoreboard bench for post_trace_buffer: directed frames push hand-computed
// expectations; independent monitors compare on o_valid, o_err and per-beat
// inhibition samples.
module tb_post_trace_buffer;

    localparam int N    = 18;
    localparam int TW   = 16;
    localparam int CW   = 7;
    localparam int IW   = 5;
    localparam int INHW = 25;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    post_trace_buffer_if #(.IDX_W(IW)) in_if ();

    logic [N-1:0]            o_spike_buf;
    logic [N*TW-1:0]         o_y1_trace;
    logic [N*TW-1:0]         o_y2_trace_buf;
    logic signed [INHW-1:0]  o_inhbt;
    logic [N*CW-1:0]         o_post_cnt;
    logic                    o_valid;
    logic                    o_err;
`ifdef POST_BUF_WTA_EN
    logic [IW-1:0]           w_idx;
    logic                    w_vld;
`endif

    post_trace_buffer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .in_if          (in_if),
        .o_spike_buf    (o_spike_buf),
        .o_y1_trace     (o_y1_trace),
        .o_y2_trace_buf (o_y2_trace_buf),
        .o_inhbt        (o_inhbt),
        .o_post_cnt     (o_post_cnt),
        .o_valid        (o_valid),
        .o_err          (o_err)
`ifdef POST_BUF_WTA_EN
        ,
        .o_winner_idx   (w_idx),
        .o_winner_vld   (w_vld)
`endif
    );

    typedef struct {
        string          name;
        logic [N-1:0]   sbuf;
        int             inh;
        int             tn;
        logic [TW-1:0]  y1;
        logic [TW-1:0]  y2;
        logic [TW-1:0]  yb;
        int             cn;
        int             cnt;
        bit             wv;
        int             wi;
    } exp_t;

    typedef struct {
        int cyc;
        int val;
    } inh_t;

    exp_t frame_q[$];
    inh_t inh_q[$];
    int   err_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last17_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_frame(input string name, input logic [N-1:0] sbuf, input int inh,
                              input int tn, input logic [TW-1:0] y1, input logic [TW-1:0] y2,
                              input logic [TW-1:0] yb, input int cn, input int cnt,
                              input bit wv, input int wi);
        exp_t e;
        e.name = name; e.sbuf = sbuf; e.inh = inh; e.tn = tn;
        e.y1 = y1; e.y2 = y2; e.yb = yb; e.cn = cn; e.cnt = cnt; e.wv = wv; e.wi = wi;
        frame_q.push_back(e);
    endtask

    task automatic beat(input int idx, input bit spk, input bit clr);
        @(negedge clk);
        in_if.i_valid   = 1'b1;
        in_if.i_idx     = IW'(idx);
        in_if.i_spike   = spk;
        in_if.i_cnt_clr = clr;
        if (idx == N - 1) last17_cyc = cyc + 1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_if.i_valid   = 1'b0;
            in_if.i_spike   = 1'b0;
            in_if.i_cnt_clr = 1'b0;
        end
    endtask

    task automatic expect_inh(input int val);
        inh_t t;
        t.cyc = cyc + 1;
        t.val = val;
        inh_q.push_back(t);
    endtask

    task automatic frame(input logic [N-1:0] spikes, input int gap);
        for (int i = 0; i < N; i++) begin
            beat(i, spikes[i], 1'b0);
            if (gap > 0 && (i % 4) == 1) idle(gap);
        end
        idle(2);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_sbuf"}, 64'(o_spike_buf), 0);
        chk({tag, "_inh"}, 64'(o_inhbt), 0);
        chk({tag, "_y1"}, 64'(|o_y1_trace), 0);
        chk({tag, "_yb"}, 64'(|o_y2_trace_buf), 0);
        chk({tag, "_cnt"}, 64'(|o_post_cnt), 0);
        chk({tag, "_valid"}, 64'(o_valid), 0);
        chk({tag, "_err"}, 64'(o_err), 0);
    endtask

    // Frame monitor: every o_valid consumes one expected frame record
    exp_t mon_e;
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n && o_valid) begin
                if (frame_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_valid: got o_valid=1 at cycle %0d required no frame", cyc);
                end else begin
                    mon_e = frame_q.pop_front();
                    chk({mon_e.name, "_valid_cycle"}, 64'(cyc), 64'(last17_cyc));
                    chk({mon_e.name, "_sbuf"}, 64'(o_spike_buf), 64'(mon_e.sbuf));
                    chk({mon_e.name, "_inh"}, 64'(o_inhbt), 64'(mon_e.inh));
                    chk({mon_e.name, "_cnt"}, 64'(o_post_cnt[mon_e.cn*CW +: CW]), 64'(mon_e.cnt));
`ifdef POST_BUF_WTA_EN
                    chk({mon_e.name, "_wvld"}, 64'(w_vld), 64'(mon_e.wv));
                    chk({mon_e.name, "_widx"}, 64'(w_idx), 64'(mon_e.wi));
`endif
                    @(negedge clk);
                    chk({mon_e.name, "_y1"}, 64'(o_y1_trace[mon_e.tn*TW +: TW]), 64'(mon_e.y1));
                    chk({mon_e.name, "_y2buf"}, 64'(o_y2_trace_buf[mon_e.tn*TW +: TW]), 64'(mon_e.yb));
                end
            end
        end
    end

    // Error monitor: o_err must appear exactly at the expected cycles
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (err_q.size() > 0 && err_q[0] < cyc) begin
                    checks++; errors++;
                    $display("FAIL missed_err: got no o_err required at cycle %0d", err_q.pop_front());
                end
                if (o_err) begin
                    if (err_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_err: got o_err=1 at cycle %0d required 0", cyc);
                    end else begin
                        chk("err_cycle", 64'(cyc), 64'(err_q.pop_front()));
                    end
                end
            end
        end
    end

    // Inhibition monitor: compares o_inhbt on the cycle after marked beats
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n && inh_q.size() > 0 && inh_q[0].cyc <= cyc) begin
                chk("inh_beat", 64'(o_inhbt), 64'(inh_q[0].val));
                void'(inh_q.pop_front());
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        in_if.i_valid   = 1'b0;
        in_if.i_spike   = 1'b0;
        in_if.i_idx     = '0;
        in_if.i_cnt_clr = 1'b0;
        reset_n         = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;
        idle(2);

        // A: no spikes
        push_frame("A", '0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1'b0, 0);
        frame('0, 0);

        // B: only neuron 3 spikes
        push_frame("B", 18'h00008, 458752, 3, 16'hFFFF, 16'hFFFF, 16'h0000, 3, 1, 1'b1, 3);
        frame(18'h00008, 0);

        // C: no spikes, neuron 3 decays once
        push_frame("C", '0, 0, 3, 16'hF000, 16'hF800, 16'hFFFF, 3, 1, 1'b0, 0);
        frame('0, 0);

        // D: spikes on 0,1,2 with the inhibition clamp
        push_frame("D", 18'h00007, 655360, 1, 16'hFFFF, 16'hFFFF, 16'h0000, 1, 1, 1'b1, 0);
        beat(0, 1'b1, 1'b0); expect_inh(458752);
        beat(1, 1'b1, 1'b0); expect_inh(655360);
        beat(2, 1'b1, 1'b0); expect_inh(655360);
        for (int i = 3; i < N; i++) beat(i, 1'b0, 1'b0);
        idle(2);

        // E: gaps mid-frame, spikes on 7 and 12; neuron 3 has decayed three times
        push_frame("E", 18'h01080, 655360, 3, 16'hD2F0, 16'hE8BE, 16'hF040, 7, 1, 1'b1, 7);
        beat(0, 1'b0, 1'b0); expect_inh(0);
        for (int i = 1; i < N; i++) begin
            beat(i, (i == 7) || (i == 12), 1'b0);
            if ((i % 3) == 0) idle(3);
        end
        idle(2);

        // F: out-of-range spiking beat mid-frame must be dropped
        push_frame("F", '0, 0, 3, 16'hC5C1, 16'hE179, 16'hE8BE, 12, 1, 1'b0, 0);
        for (int i = 0; i < N; i++) begin
            beat(i, 1'b0, 1'b0);
            if (i == 8) begin
                beat(20, 1'b1, 1'b0);
                err_q.push_back(cyc + 1);
            end
        end
        idle(2);

        // Counter saturation: neuron 5 spikes in 130 frames
        for (int k = 1; k <= 130; k++) begin
            push_frame("SAT", 18'h00020, 458752, 5, 16'hFFFF, 16'hFFFF,
                       (k == 1) ? 16'h0000 : 16'hFFFF, 5, (k < 127) ? k : 127, 1'b1, 5);
            frame(18'h00020, 0);
        end

        // Clear coinciding with a spike: clear wins
        push_frame("CLR", 18'h00020, 458752, 5, 16'hFFFF, 16'hFFFF, 16'hFFFF, 5, 0, 1'b1, 5);
        for (int i = 0; i < N; i++) beat(i, i == 5, i == 5);
        idle(2);

        // Back-to-back same index: second beat must see the first beat's result
        push_frame("HAZ", '0, 0, 0, 16'hF000, 16'hF800, 16'hFFFF, 0, 1, 1'b0, 0);
        beat(0, 1'b1, 1'b0);
        beat(0, 1'b0, 1'b0);
        for (int i = 1; i < N; i++) beat(i, 1'b0, 1'b0);
        idle(2);

        // Reset in the middle of a frame flushes everything
        for (int i = 0; i < 9; i++) beat(i, i == 2, 1'b0);
        @(negedge clk);
        in_if.i_valid = 1'b0;
        in_if.i_spike = 1'b0;
        reset_n = 1'b0;
        #1;
        check_all_zero("midrst");
        idle(2);
        reset_n = 1'b1;
        idle(2);

        push_frame("A2", '0, 0, 2, 16'h0000, 16'h0000, 16'h0000, 2, 0, 1'b0, 0);
        frame('0, 0);

        idle(6);
        chk("frame_q_left", 64'(frame_q.size()), 0);
        chk("inh_q_left", 64'(inh_q.size()), 0);
        chk("err_q_left", 64'(err_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
